// File: rtl/approx_mult_pkg.sv
// Shared constants and helpers for the approximate multiplier pipeline stages.
package approx_mult_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_TRUNC = 4;
  localparam int DEF_CNT_W = 16;
  localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = '1;

  // Row = multiplier bit index, col = multiplicand bit index.
  function automatic int pp_idx(input int row, input int col, input int width);
    return row * width + col;
  endfunction

  function automatic logic trunc_keep(input int row, input int col, input int trunc);
    return (row + col) >= trunc;
  endfunction

endpackage

// File: rtl/approx_pp_gen_cg_if.sv
// Operand-in / partial-product-out handshake bundle between the multiplier front end and the compressor tree.
interface approx_pp_gen_cg_if
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_a;
  logic [WIDTH-1:0]         in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*WIDTH-1:0]   pp_flat;
  logic                     zero_flag;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, pp_flat, zero_flag
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, pp_flat, zero_flag
  );
endinterface

// File: rtl/clk_gate_icg.sv
// Behavioural integrated clock gate: enable latched while clk is low, so gclk never glitches.
module clk_gate_icg (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic gclk
);
  logic en_lat_q;

  always_latch begin
    if (!clk) en_lat_q <= en | test_en;
  end

  assign gclk = clk & en_lat_q;
endmodule

// File: rtl/approx_pp_gen_cg.sv
// Clock-gated AND-array partial-product stage; 1-cycle latency from accept to out_valid.
// Stalls (in_ready low, outputs frozen) while out_valid is held against out_ready low.
module approx_pp_gen_cg
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TRUNC = DEF_TRUNC,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              test_en,
  approx_pp_gen_cg_if.slave bus,
  output logic              gate_en,
  output logic [CNT_W-1:0]  gated_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic                   held_valid_q, held_valid_d;
  logic                   zero_q, zero_d;
  logic                   out_valid_q, out_valid_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   gclk, accept, in_zero, same;
  logic [WIDTH*WIDTH-1:0] pp;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_zero      = (bus.in_a == '0) || (bus.in_b == '0);
  assign same         = held_valid_q && (bus.in_a == a_q) && (bus.in_b == b_q);
  assign gate_en      = accept && !in_zero && !same;

  clk_gate_icg u_icg (
    .clk     (clk),
    .en      (gate_en),
    .test_en (test_en),
    .gclk    (gclk)
  );

  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    held_valid_d = held_valid_q;
    zero_d       = zero_q;
    out_valid_d  = out_valid_q;
    cnt_d        = cnt_q;
    if (accept) begin
      zero_d      = in_zero;
      out_valid_d = 1'b1;
      if (gate_en) begin
        a_d          = bus.in_a;
        b_d          = bus.in_b;
        held_valid_d = 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // The gate may be held open by test_en, so the operand regs still self-select on gate_en.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid_q <= 1'b0;
      zero_q       <= 1'b1;
      out_valid_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      zero_q       <= zero_d;
      out_valid_q  <= out_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp[pp_idx(i, j, WIDTH)] = !zero_q && a_q[j] && b_q[i] && trunc_keep(i, j, TRUNC);
      end
    end
  end

  assign bus.pp_flat   = pp;
  assign bus.zero_flag = zero_q;
  assign bus.out_valid = out_valid_q;
  assign gated_cnt     = cnt_q;
endmodule

// File: tb/tb_approx_pp_gen_cg.sv
module tb_approx_pp_gen_cg;
  import approx_mult_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_en = 1'b0;
  logic gate_en0, gate_en1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  int compared = 0;
  int mismatched = 0;
  int g0 = 0;
  int g1 = 0;

  approx_pp_gen_cg_if #(.WIDTH(8)) bus0 ();
  approx_pp_gen_cg_if #(.WIDTH(8)) bus1 ();

  approx_pp_gen_cg #(.WIDTH(8), .TRUNC(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .test_en(test_en), .bus(bus0),
    .gate_en(gate_en0), .gated_cnt(cnt0)
  );
  approx_pp_gen_cg #(.WIDTH(8), .TRUNC(4), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .test_en(test_en), .bus(bus1),
    .gate_en(gate_en1), .gated_cnt(cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge u_dut0.gclk) g0++;
  always @(posedge u_dut1.gclk) g1++;

  // Reference state: last captured non-zero, non-repeat pair and the unsaturated gated count.
  logic [7:0] m_a, m_b;
  bit m_hv, m_z, m_ov;
  int m_cnt;

  function automatic logic [63:0] pp_ref(input logic [7:0] a, input logic [7:0] b,
                                         input bit z, input int trunc);
    logic [63:0] r;
    logic [15:0] row;
    r = '0;
    if (z) return r;
    for (int i = 0; i < 8; i++) begin
      row = b[i] ? {8'h00, a} : 16'h0;
      if (trunc > i) row = row & ~((16'd1 << (trunc - i)) - 16'd1);
      r = r | (64'(row[7:0]) << (8 * i));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic r, input logic ten);
    bus0.in_valid = v; bus0.in_a = a; bus0.in_b = b; bus0.out_ready = r;
    bus1.in_valid = v; bus1.in_a = a; bus1.in_b = b; bus1.out_ready = r;
    test_en = ten;
  endtask

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_hv = 0; m_z = 1; m_ov = 0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid0"}, 64'(bus0.out_valid), 64'(m_ov));
    chk({tag, ".out_valid1"}, 64'(bus1.out_valid), 64'(m_ov));
    chk({tag, ".zero_flag0"}, 64'(bus0.zero_flag), 64'(m_z));
    chk({tag, ".zero_flag1"}, 64'(bus1.zero_flag), 64'(m_z));
    chk({tag, ".pp0"}, bus0.pp_flat, pp_ref(m_a, m_b, m_z, 0));
    chk({tag, ".pp1"}, bus1.pp_flat, pp_ref(m_a, m_b, m_z, 4));
    chk({tag, ".cnt0"}, 64'(cnt0), 64'(m_cnt));
    chk({tag, ".cnt1"}, 64'(cnt1), 64'((m_cnt > 3) ? 3 : m_cnt));
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic r, input logic ten);
    bit exp_rdy, acc, zr, sm, ge;
    int g0s, g1s;
    @(negedge clk);
    drive(v, a, b, r, ten);
    #1;
    exp_rdy = !m_ov || r;
    acc = v && exp_rdy;
    zr = (a == 0) || (b == 0);
    sm = m_hv && (a == m_a) && (b == m_b);
    ge = acc && !zr && !sm;
    chk({tag, ".in_ready"}, 64'(bus0.in_ready), 64'(exp_rdy));
    chk({tag, ".in_ready1"}, 64'(bus1.in_ready), 64'(exp_rdy));
    chk({tag, ".gate_en0"}, 64'(gate_en0), 64'(ge));
    chk({tag, ".gate_en1"}, 64'(gate_en1), 64'(ge));
    g0s = g0;
    g1s = g1;
    @(posedge clk);
    #1;
    if (acc) begin
      m_z = zr;
      m_ov = 1;
      if (ge) begin m_a = a; m_b = b; m_hv = 1; end
      else m_cnt++;
    end else if (r) begin
      m_ov = 0;
    end
    chk({tag, ".gclk0"}, 64'(g0 - g0s), 64'(ge || ten));
    chk({tag, ".gclk1"}, 64'(g1 - g1s), 64'(ge || ten));
    check_outputs(tag);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".out_valid"}, 64'(bus0.out_valid), 64'd0);
    chk({tag, ".zero_flag"}, 64'(bus1.zero_flag), 64'd1);
    chk({tag, ".pp0"}, bus0.pp_flat, 64'd0);
    chk({tag, ".pp1"}, bus1.pp_flat, 64'd0);
    chk({tag, ".in_ready"}, 64'(bus0.in_ready), 64'd1);
    chk({tag, ".cnt0"}, 64'(cnt0), 64'd0);
    chk({tag, ".cnt1"}, 64'(cnt1), 64'd0);
    chk({tag, ".gate_en"}, 64'(gate_en0), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [6];
    logic [7:0] ra, rb;
    vals[0] = 8'h00; vals[1] = 8'hA5; vals[2] = 8'h03;
    vals[3] = 8'h7F; vals[4] = 8'hFF; vals[5] = 8'h01;

    drive(0, 8'h00, 8'h00, 1, 0);
    model_reset();
    #12;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    step("idle", 0, 8'h00, 8'h00, 1, 0);
    step("idle", 0, 8'h00, 8'h00, 1, 0);

    step("first", 1, 8'hA5, 8'h03, 1, 0);
    chk("first.const0", bus0.pp_flat, 64'h0000_0000_0000_A5A5);
    chk("first.const1", bus1.pp_flat, 64'h0000_0000_0000_A0A0);
    step("drain", 0, 8'h00, 8'h00, 1, 0);

    for (int k = 0; k < 5; k++) step("repeat", 1, 8'hA5, 8'h03, 1, 0);
    chk("sat.cnt1", 64'(cnt1), 64'd3);

    step("zero", 1, 8'h00, 8'h7F, 1, 0);
    step("zrep", 1, 8'hA5, 8'h03, 1, 0);
    chk("zrep.const0", bus0.pp_flat, 64'h0000_0000_0000_A5A5);

    step("bp_load", 1, 8'h11, 8'h22, 1, 0);
    for (int k = 0; k < 5; k++) step("bp_hold", 1, 8'h33, 8'h44, 0, 0);
    step("bp_release", 1, 8'h33, 8'h44, 1, 0);

    for (int k = 0; k < 3; k++) step("test_en", 0, 8'h00, 8'h00, 1, 1);
    step("test_en_acc", 1, 8'h55, 8'h66, 1, 1);
    step("test_en_rep", 1, 8'h55, 8'h66, 1, 1);

    step("pre_rst", 1, 8'h77, 8'h88, 1, 0);
    step("hold_rst", 1, 8'h99, 8'hAA, 0, 0);
    @(negedge clk);
    drive(0, 8'h00, 8'h00, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 400; k++) begin
      ra = vals[$urandom_range(0, 5)];
      rb = vals[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) ra = 8'($urandom);
      step("rand", 1'($urandom_range(0, 3) != 0), ra, rb,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
